// File: rtl/blowfish128_feistel.sv
// rtl/blowfish128_feistel.sv - iterative Blowfish-128 Feistel round controller
// Sequences key-mix, external F-function and XOR/swap rounds, then output whitening.
module blowfish128_feistel #(
  parameter int ROUNDS = 16,
  localparam int PIW = $clog2(ROUNDS + 2)
) (
  input  logic           Clk,
  input  logic           RstN,
  input  logic           Start,
  input  logic           Decrypt,
  input  logic [127:0]   DataIn,
  output logic           Ready,
  output logic [127:0]   DataOut,
  output logic           outputValid,
  output logic [PIW-1:0] PIdx,
  input  logic [63:0]    PKey,
  output logic           ffEnable,
  output logic [63:0]    ffX,
  input  logic [63:0]    ffY,
  input  logic           ffValid
);

  typedef enum logic [2:0] {
    S_IDLE, S_KEYMIX, S_FWAIT, S_FIN_R, S_FIN_L, S_DONE
  } state_t;

  state_t         state;
  logic [63:0]    l, r;
  logic [PIW-1:0] rnd;
  logic           dec;

  // Decryption walks the P-array backwards.
  function automatic logic [PIW-1:0] kidx(input logic [PIW-1:0] i, input logic d);
    return d ? (PIW'(ROUNDS + 1) - i) : i;
  endfunction

  always_ff @(posedge Clk or negedge RstN) begin
    if (!RstN) begin
      state       <= S_IDLE;
      l           <= '0;
      r           <= '0;
      rnd         <= '0;
      dec         <= 1'b0;
      PIdx        <= '0;
      ffEnable    <= 1'b0;
      ffX         <= '0;
      DataOut     <= '0;
      Ready       <= 1'b1;
      outputValid <= 1'b0;
    end else begin
      case (state)
        S_IDLE, S_DONE: begin
          if (Start) begin
            l           <= DataIn[127:64];
            r           <= DataIn[63:0];
            dec         <= Decrypt;
            rnd         <= '0;
            PIdx        <= kidx('0, Decrypt);
            Ready       <= 1'b0;
            outputValid <= 1'b0;
            state       <= S_KEYMIX;
          end
        end
        S_KEYMIX: begin
          // ffEnable is low for this whole cycle, which clears the F pipeline.
          l        <= l ^ PKey;
          ffX      <= l ^ PKey;
          ffEnable <= 1'b1;
          state    <= S_FWAIT;
        end
        S_FWAIT: begin
          if (ffValid) begin
            ffEnable <= 1'b0;
            if (rnd != PIW'(ROUNDS - 1)) begin
              l     <= r ^ ffY;
              r     <= l;
              rnd   <= rnd + PIW'(1);
              PIdx  <= kidx(rnd + PIW'(1), dec);
              state <= S_KEYMIX;
            end else begin
              r     <= r ^ ffY;
              PIdx  <= dec ? PIW'(1) : PIW'(ROUNDS);
              state <= S_FIN_R;
            end
          end
        end
        S_FIN_R: begin
          r     <= r ^ PKey;
          PIdx  <= dec ? PIW'(0) : PIW'(ROUNDS + 1);
          state <= S_FIN_L;
        end
        S_FIN_L: begin
          l           <= l ^ PKey;
          DataOut     <= {l ^ PKey, r};
          outputValid <= 1'b1;
          Ready       <= 1'b1;
          state       <= S_DONE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
